// File: rtl/canvas_i2c_pkg.sv
// canvas_i2c_pkg
// Shared definitions for the canvas I2C controller: the transaction state
// enum, the I2C protocol bit values and the default target address.
package canvas_i2c_pkg;

  // Transaction phases in bus order.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    ADDR   = 3'd2,
    ACK_A  = 3'd3,
    DATA   = 3'd4,
    ACK_D  = 3'd5,
    STOP   = 3'd6
  } i2c_state_e;

  // R/W bit value for a write and the SDA level a target drives to ACK.
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_ACK   = 1'b0;

  // Canvas core listens on this 7-bit address.
  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h2A;

endpackage

// File: rtl/canvas_i2c_master_if.sv
// canvas_i2c_master_if
// Byte handshake and open-drain bus signals of the canvas I2C controller.
//   tx_valid/tx_ready/tx_data : one status byte per transaction
//   busy/done/nack            : transaction status
//   scl_i/sda_i               : sampled bus lines
//   scl_oe/sda_oe             : 1 = pull the line low
// modport master : the controller side
// modport slave  : the host / bus-environment side
interface canvas_i2c_master_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic       nack;
  logic       scl_i;
  logic       scl_oe;
  logic       sda_i;
  logic       sda_oe;

  modport master (
    input  tx_valid, tx_data, scl_i, sda_i,
    output tx_ready, busy, done, nack, scl_oe, sda_oe
  );

  modport slave (
    output tx_valid, tx_data, scl_i, sda_i,
    input  tx_ready, busy, done, nack, scl_oe, sda_oe
  );
endinterface

// File: rtl/canvas_i2c_tick.sv
// canvas_i2c_tick
// Quarter-bit divider. Pulses qtick on the last cycle of every CLK_DIV-cycle
// quarter. clr holds the count at zero; stall freezes it (and suppresses the
// pulse) so a quarter can be stretched.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the quarter from its first cycle
//   stall    : hold the current count
//   qtick    : one-cycle pulse marking the last cycle of a quarter
module canvas_i2c_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic stall,
  output logic qtick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (!stall) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign qtick = (cnt == LAST) && !stall;

endmodule

// File: rtl/canvas_i2c_master.sv
// canvas_i2c_master
// I2C write-only controller carrying one canvas status byte per transaction:
// START, {DEV_ADDR, W}, ACK slot, data byte, ACK slot, STOP. A NACK in either
// ACK slot ends the transaction with STOP and raises nack alongside done.
// Each bit slot is four quarters of CLK_DIV cycles.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset; releases both lines at once
//   bus  : canvas_i2c_master_if.master (handshake, status, SCL/SDA)
// Build option:
//   CANVAS_I2C_CLK_STRETCH_EN - honour target clock stretching: the quarter in
//   which SCL is released after being low waits while scl_i is still low.
//   Without it scl_i is ignored and timing is fixed.
module canvas_i2c_master
  import canvas_i2c_pkg::*;
#(
  parameter int         CLK_DIV  = 4,
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  canvas_i2c_master_if.master bus
);

  i2c_state_e state_q, state_d;
  logic [1:0] q_q, q_d;          // quarter index within the bit slot
  logic [2:0] bit_q, bit_d;      // bit index within the byte
  logic [7:0] sh_q, sh_d;        // outgoing byte, MSB on the wire
  logic [7:0] data_q, data_d;    // status byte latched at accept
  logic       nack_q, nack_d;
  logic       done_q, done_d;
  logic       scl_oe_q, sda_oe_q;
  logic [1:0] drv_d;

  logic qtick;
  logic tick_clr;
  logic tick_stall;

  // Line drive per phase and quarter: returns {scl_oe, sda_oe}.
  function automatic logic [1:0] line_drive(input i2c_state_e st,
                                            input logic [1:0] qi,
                                            input logic       b);
    logic scl_low;
    scl_low = (qi == 2'd0) || (qi == 2'd3);
    case (st)
      START:        line_drive = {1'b0, qi[1]};
      ADDR, DATA:   line_drive = {scl_low, ~b};
      ACK_A, ACK_D: line_drive = {scl_low, 1'b0};
      STOP: begin
        case (qi)
          2'd0:    line_drive = 2'b11;
          2'd1:    line_drive = 2'b01;
          default: line_drive = 2'b00;
        endcase
      end
      default:      line_drive = 2'b00;
    endcase
  endfunction

  // The divider idles at zero so the first quarter after accept is full length.
  assign tick_clr = (state_q == IDLE);

`ifdef CANVAS_I2C_CLK_STRETCH_EN
  // Quarter 1 of every clocked slot (and of STOP) is where SCL is let go
  // after being held low; a target still holding it low extends that quarter.
  logic release_qtr;
  assign release_qtr = (q_q == 2'd1) &&
                       (state_q inside {ADDR, ACK_A, DATA, ACK_D, STOP});
  assign tick_stall  = release_qtr && !bus.scl_i;
`else
  logic unused_scl;
  assign unused_scl = bus.scl_i;
  assign tick_stall = 1'b0;
`endif

  canvas_i2c_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (tick_clr),
    .stall (tick_stall),
    .qtick (qtick)
  );

  // Next-state and datapath decode
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    nack_d  = nack_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.tx_valid) begin
          state_d = START;
          q_d     = 2'd0;
          bit_d   = 3'd0;
          data_d  = bus.tx_data;
          sh_d    = {DEV_ADDR, I2C_WRITE};
          nack_d  = 1'b0;
        end
      end

      START: begin
        if (qtick) begin
          q_d = q_q + 2'd1;
          if (q_q == 2'd3) state_d = ADDR;
        end
      end

      ADDR, DATA: begin
        if (qtick) begin
          q_d = q_q + 2'd1;
          if (q_q == 2'd3) begin
            sh_d  = {sh_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = (state_q == ADDR) ? ACK_A : ACK_D;
          end
        end
      end

      ACK_A, ACK_D: begin
        if (qtick) begin
          q_d = q_q + 2'd1;
          // The q2 tick is the last cycle with SCL high: sample the target here.
          if (q_q == 2'd2) nack_d = (bus.sda_i != I2C_ACK);
          if (q_q == 2'd3) begin
            if (nack_q || state_q == ACK_D) begin
              state_d = STOP;
            end else begin
              state_d = DATA;
              sh_d    = data_q;
              bit_d   = 3'd0;
            end
          end
        end
      end

      STOP: begin
        // q stays at 3 after the final tick so the lines remain released
        // during the done cycle; IDLE follows one cycle after done.
        if (done_q) begin
          state_d = IDLE;
        end else if (qtick) begin
          if (q_q == 2'd3) done_d = 1'b1;
          else             q_d    = q_q + 2'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so the bus lines
  // change on the same edge as the phase, without decode glitches.
  assign drv_d = line_drive(state_d, q_d, sh_d[7]);

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      q_q      <= 2'd0;
      bit_q    <= 3'd0;
      nack_q   <= 1'b0;
      done_q   <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      bit_q    <= bit_d;
      nack_q   <= nack_d;
      done_q   <= done_d;
      scl_oe_q <= drv_d[1];
      sda_oe_q <= drv_d[0];
    end
  end

  // Data registers
  always_ff @(posedge clk) begin
    sh_q   <= sh_d;
    data_q <= data_d;
  end

  assign bus.tx_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.nack     = nack_q;
  assign bus.scl_oe   = scl_oe_q;
  assign bus.sda_oe   = sda_oe_q;

endmodule

// File: tb/tb_canvas_i2c_master.sv
// tb_canvas_i2c_master
// Drives canvas_i2c_master with directed and random status bytes against a
// behavioural I2C target that ACKs/NACKs on request, decodes START/STOP and
// the bits clocked on SCL rising edges, and compares frames, latency and
// status flags with values derived from the I2C transaction rules.
module tb_canvas_i2c_master;

  localparam int         CLK_DIV   = 2;
  localparam logic [7:0] ADDR_BYTE = {7'h2A, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  canvas_i2c_master_if bus ();

  canvas_i2c_master #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Open-drain wiring: a line is high unless someone pulls it.
  logic tgt_sda  = 1'b0;
  logic tgt_hold = 1'b0;
  assign bus.sda_i = ~bus.sda_oe & ~tgt_sda;
  assign bus.scl_i = ~bus.scl_oe & ~tgt_hold;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Cycle and handshake bookkeeping
  int edge_n  = 0;
  int acc_cnt = 0;
  int rdy_cnt = 0;
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!rst && bus.tx_ready) rdy_cnt <= rdy_cnt + 1;
    if (!rst && bus.tx_ready && bus.tx_valid) acc_cnt <= acc_cnt + 1;
  end

  // Behavioural I2C target and bus monitor
  logic scl_p = 1'b1, sda_p = 1'b1, scl_oe_p = 1'b0;
  int   n_start = 0, n_stop = 0, nbits = 0, hold_left = 0;
  logic bits[$];
  bit   cfg_ack_a = 1'b1, cfg_ack_d = 1'b1, stretch_req = 1'b0;

  always @(negedge clk) begin
    logic scl_l, sda_l;
    if (stretch_req && scl_oe_p && !bus.scl_oe && nbits == 0) begin
      hold_left   = 10;
      stretch_req = 1'b0;
    end
    tgt_hold = (hold_left > 0);
    if (hold_left > 0) hold_left--;
    if (rst) tgt_sda = 1'b0;
    scl_l = ~bus.scl_oe & ~tgt_hold;
    sda_l = ~bus.sda_oe & ~tgt_sda;
    if (scl_p && scl_l && sda_p && !sda_l) begin
      n_start++;
      nbits = 0;
      bits.delete();
    end else if (scl_p && scl_l && !sda_p && sda_l) begin
      n_stop++;
    end
    if (!scl_p && scl_l) begin
      bits.push_back(sda_l);
      nbits++;
    end
    if (scl_p && !scl_l) begin
      if ((nbits == 8 && cfg_ack_a) || (nbits == 17 && cfg_ack_d)) tgt_sda = 1'b1;
      if (nbits == 9 || nbits == 18) tgt_sda = 1'b0;
    end
    scl_p    = scl_l;
    sda_p    = ~bus.sda_oe & ~tgt_sda;
    scl_oe_p = bus.scl_oe;
  end

  function automatic logic [7:0] frame_byte(input int first);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[6:0], bits[first + i]};
    return v;
  endfunction

  // One transaction; called just after a falling clock edge.
  task automatic run_txn(input logic [7:0] d, input bit ack_a, input bit ack_d,
                         input bit keep_valid, input int extra, input string tag);
    int  t_acc, t_done, s0, p0, exp_lat, exp_bits;
    bit  got_acc, got_done, exp_nack;
    cfg_ack_a    = ack_a;
    cfg_ack_d    = ack_d;
    s0           = n_start;
    p0           = n_stop;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    got_acc      = 1'b0;
    t_acc        = 0;
    for (int i = 0; i < 400 && !got_acc; i++) begin
      if (bus.tx_ready) begin
        got_acc = 1'b1;
        t_acc   = edge_n + 1;
      end
      @(negedge clk);
    end
    check({tag, "/accept"}, int'(got_acc), 1);
    if (!got_acc) begin
      bus.tx_valid = 1'b0;
      return;
    end
    if (!keep_valid) bus.tx_valid = 1'b0;
    bus.tx_data = ~d;
    check({tag, "/busy"}, int'(bus.busy), 1);
    check({tag, "/ready_low"}, int'(bus.tx_ready), 0);
    check({tag, "/nack_clr"}, int'(bus.nack), 0);

    got_done = 1'b0;
    t_done   = 0;
    for (int i = 0; i < 2000 && !got_done; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got_done = 1'b1;
        t_done   = edge_n;
      end
    end
    check({tag, "/done_seen"}, int'(got_done), 1);
    if (!got_done) begin
      bus.tx_valid = 1'b0;
      return;
    end

    // START + 8 address bits + ACK (+ 8 data bits + ACK) + STOP, 4 quarters each.
    exp_lat  = (ack_a ? 20 : 11) * 4 * CLK_DIV + extra;
    exp_nack = !(ack_a && ack_d);
    // Rising SCL edges: every clocked bit plus the STOP set-up rise.
    exp_bits = ack_a ? 19 : 10;
    check({tag, "/latency"}, t_done - t_acc, exp_lat);
    check({tag, "/nack"}, int'(bus.nack), int'(exp_nack));
    check({tag, "/scl_rel"}, int'(bus.scl_oe), 0);
    check({tag, "/sda_rel"}, int'(bus.sda_oe), 0);
    check({tag, "/starts"}, n_start - s0, 1);
    check({tag, "/stops"}, n_stop - p0, 1);
    check({tag, "/nbits"}, bits.size(), exp_bits);
    if (bits.size() == exp_bits) begin
      check({tag, "/addr"}, int'(frame_byte(0)), int'(ADDR_BYTE));
      check({tag, "/ack_a"}, int'(bits[8]), int'(!ack_a));
      if (ack_a) begin
        check({tag, "/data"}, int'(frame_byte(9)), int'(d));
        check({tag, "/ack_d"}, int'(bits[17]), int'(!ack_d));
      end
    end
    if (!keep_valid) begin
      @(negedge clk);
      check({tag, "/ready_after"}, int'(bus.tx_ready), 1);
      check({tag, "/idle_busy"}, int'(bus.busy), 0);
      check({tag, "/nack_hold"}, int'(bus.nack), int'(exp_nack));
      check({tag, "/done_pulse"}, int'(bus.done), 0);
    end
  endtask

  initial begin
    int  a0, r0;
    bit  reached;
    logic [7:0] d;

    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst/tx_ready", int'(bus.tx_ready), 1);
    check("rst/busy", int'(bus.busy), 0);
    check("rst/done", int'(bus.done), 0);
    check("rst/nack", int'(bus.nack), 0);
    check("rst/scl_oe", int'(bus.scl_oe), 0);
    check("rst/sda_oe", int'(bus.sda_oe), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_txn(8'hB5, 1'b1, 1'b1, 1'b0, 0, "full_b5");
    run_txn(8'($urandom), 1'b0, 1'b1, 1'b0, 0, "addr_nack");
    run_txn(8'($urandom), 1'b1, 1'b0, 1'b0, 0, "data_nack");
    run_txn(8'($urandom), 1'b1, 1'b1, 1'b0, 0, "after_nack");

    // tx_valid held across two back-to-back transactions
    a0 = acc_cnt;
    run_txn(8'h3C, 1'b1, 1'b1, 1'b1, 0, "held1");
    r0 = rdy_cnt;
    run_txn(8'hC3, 1'b1, 1'b1, 1'b1, 0, "held2");
    bus.tx_valid = 1'b0;
    check("held/ready_gap", rdy_cnt - r0, 1);
    repeat (6) @(negedge clk);
    check("held/accepts", acc_cnt - a0, 2);

    // Reset in the middle of data bit 3
    cfg_ack_a    = 1'b1;
    cfg_ack_d    = 1'b1;
    bus.tx_data  = 8'($urandom);
    bus.tx_valid = 1'b1;
    reached      = 1'b0;
    for (int i = 0; i < 400 && !bus.tx_ready; i++) @(negedge clk);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 1000 && !reached; i++) begin
      @(negedge clk);
      if (nbits == 13) reached = 1'b1;
    end
    check("midrst/reached_bit3", int'(reached), 1);
    check("midrst/busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst/scl_oe", int'(bus.scl_oe), 0);
    check("midrst/sda_oe", int'(bus.sda_oe), 0);
    check("midrst/busy", int'(bus.busy), 0);
    check("midrst/tx_ready", int'(bus.tx_ready), 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_txn(8'($urandom), 1'b1, 1'b1, 1'b0, 0, "post_rst");

    // Random bytes with random target responses
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      run_txn(d, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              1'b0, 0, $sformatf("rnd%0d", k));
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

`ifdef CANVAS_I2C_CLK_STRETCH_EN
    stretch_req = 1'b1;
    run_txn(8'($urandom), 1'b1, 1'b1, 1'b0, 10, "stretch");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/canvas_i2c_master.md
Name: canvas_i2c_master

Overview:
- I2C controller (initiator) that carries one canvas status byte to the canvas I2C target.
- Accepts one byte per transaction on a valid/ready handshake.
- Each transaction is START, 7-bit address + W, one data byte, STOP.
- Drives open-drain SCL/SDA through output enables. Detects NACK on both the address and data phases.
- Sits on the MCU/host side of the canvas board and feeds the same SCL/SDA pair the canvas core listens on.

Parameters:
- CLK_DIV, 4, clk cycles per quarter bit (min 1). One bit = 4*CLK_DIV cycles.
- DEV_ADDR, 7'h2A, 7-bit target address sent in the address byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_valid  in  1  byte offered
- tx_ready  out  1  high only in IDLE
- tx_data  in  8  status byte {color[2:0], up, down, right, left, brush}
- busy  out  1  high from accept until done
- done  out  1  one-cycle pulse at end of transaction
- nack  out  1  valid with done; 1 = target NACKed (address or data)
- scl_i  in  1  sampled SCL line
- scl_oe  out  1  1 = pull SCL low
- sda_i  in  1  sampled SDA line
- sda_oe  out  1  1 = pull SDA low

Behaviour:
- Reset state: tx_ready=1; busy=0; done=0; nack=0; scl_oe=0; sda_oe=0; state IDLE; divider=0.
- Reset mid-transaction: both lines are released on the reset edge. No STOP is generated.
- Accept: tx_valid && tx_ready at edge T latches tx_data. Later changes on tx_data are ignored.
  - busy=1 and tx_ready=0 from T+1.
  - tx_valid while busy is not consumed.
- Quarter tick: a divider pulses every CLK_DIV cycles. Quarter index q runs 0..3 per bit slot.
- States: IDLE -> START -> ADDR(8 bits, MSB first, {DEV_ADDR,0}) -> ACK_A -> DATA(8 bits, MSB first) -> ACK_D -> STOP -> IDLE.
- START: q0–q1 both released; q2–q3 SDA low, SCL released.
- Data bit:
  - q0: SCL low, SDA set (oe = ~bit).
  - q1–q2: SCL released.
  - q3: SCL low.
- ACK slot: SDA released; sda_i sampled on the last cycle of q2.
  - 0 = ACK, continue.
  - 1 = NACK: go directly to STOP with the nack flag set.
- STOP:
  - q0: SCL low, SDA low.
  - q1: SCL released, SDA low.
  - q2–q3: both released.
- done: asserted on the cycle STOP q3 completes. nack is valid with done and held until the next accept.
- Return to IDLE: tx_ready=1 the cycle after done.
- Latency (no stretching), done asserted at:
  - full transaction: T + 80*CLK_DIV (20 bit slots).
  - address NACK: T + 44*CLK_DIV (START + 9 + STOP).
- Arbitration loss is not detected (single-master bus).

Optional Feature:
- Macro: CANVAS_I2C_CLK_STRETCH_EN.
- When defined:
  - In every quarter where SCL is released after being low, the divider freezes while scl_i==0. Target clock stretching extends that quarter.
  - Latency grows by the stretch cycles.
- When undefined:
  - scl_i is ignored.
  - Timing is fixed as above.

Decomposition:
- Package canvas_i2c_pkg holds:
  - state enum (IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP)
  - I2C_WRITE=1'b0, I2C_ACK=1'b0
  - default DEV_ADDR
- One sub-module, canvas_i2c_tick: the CLK_DIV divider with stall input, producing the quarter pulse.
- Bit counter, shift register and FSM stay in canvas_i2c_master.

Test Plan:
- CLK_DIV=2, target ACKs both, tx_data=8'hB5 -> SDA shows 0x54 then 0xB5 MSB-first on SCL rising edges; done at T+160; nack=0; lines released after.
- Address NACK (sda_i held 1) -> no data bits clocked; STOP follows ACK_A; done at T+88; nack=1.
- Data NACK -> full address+data sent; done at T+160; nack=1; next accept clears nack.
- tx_valid held high continuously -> exactly one accept per transaction; tx_ready=1 for exactly one cycle between transactions; tx_data change after accept not transmitted.
- rst pulsed mid DATA bit 3 -> scl_oe=sda_oe=0, busy=0, tx_ready=1 next cycle; following transaction is a clean START.
- CANVAS_I2C_CLK_STRETCH_EN defined, target holds SCL low 10 cycles during ADDR bit 0 -> done delayed by exactly 10 cycles; bit timing otherwise unchanged.
